// File: rtl/fp_int_mul_pkg.sv
// Shared definitions for the FP16 x signed-INT MAC datapath.
//   - FP16 field widths and bias
//   - FSM state encoding for the bit-serial multiplier
//   - product width (significand width plus weight width)
//   - fp16_unpack: split an FP16 word into sign, biased exponent and
//     significand with the hidden bit restored (0 for subnormals/zero)
package fp_int_mul_pkg;

    localparam int EXP_W       = 5;
    localparam int FRAC_W      = 10;
    localparam int SIG_W       = 11;
    localparam int EXP_BIAS    = 15;
    localparam int W_WIDTH_DEF = 4;
    localparam int PROD_W      = SIG_W + W_WIDTH_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp16_fields_t;

    // Inf/NaN are not special-cased: their fields flow through unchanged.
    function automatic fp16_fields_t fp16_unpack(input logic [15:0] a);
        fp16_fields_t r;
        r.sign = a[15];
        r.exp  = a[14:10];
        r.sig  = {(a[14:10] != 5'd0), a[9:0]};
        return r;
    endfunction

endpackage

// File: rtl/fp_int_mul.sv
// Sequential FP16 x signed-INT multiplier (bit-serial shift-add).
// Produces an unnormalized sign / biased exponent / integer mantissa
// triple for the downstream accumulator to align and sum.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   activation   in   FP16 operand, sampled on an accepted start
//   weight       in   two's-complement weight, sampled on an accepted start
//   start        in   request, accepted when busy=0
//   busy         out  multiply in progress
//   sign_out     out  product sign (registered)
//   exp_out      out  activation biased exponent (registered)
//   mantissa_out out  significand * |weight| (registered)
//   done         out  result valid, held until the next accepted start
module fp_int_mul
    import fp_int_mul_pkg::*;
#(
    parameter int ACT_WIDTH = 16,
    parameter int W_WIDTH   = 4,
    parameter int ACC_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ACT_WIDTH-1:0]     activation,
    input  logic [W_WIDTH-1:0]       weight,
    input  logic                     start,
    output logic                     busy,
    output logic                     sign_out,
    output logic [EXP_W-1:0]         exp_out,
    output logic [SIG_W+W_WIDTH-1:0] mantissa_out,
    output logic                     done
);

    localparam int MANT_W = SIG_W + W_WIDTH;
    localparam int CNT_W  = $clog2(W_WIDTH + 1);

    // Elaboration-time guards on the parameter set.
    if (ACT_WIDTH != 16) begin : g_bad_act_width
        $error("fp_int_mul: only FP16 activations are supported");
    end
    if (ACC_WIDTH < MANT_W) begin : g_bad_acc_width
        $error("fp_int_mul: accumulator narrower than the product");
    end

    state_e              state_q;
    logic [SIG_W-1:0]    m_q;
    logic [W_WIDTH-1:0]  w_q;
    logic [MANT_W-1:0]   acc_q;
    logic [MANT_W-1:0]   acc_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                sign_q;
    logic [EXP_W-1:0]    exp_q;
    logic                sign_out_q;
    logic [EXP_W-1:0]    exp_out_q;
    logic [MANT_W-1:0]   mant_out_q;
    logic                done_q;

    fp16_fields_t        act_f;
    logic [W_WIDTH-1:0]  w_mag;
    logic [MANT_W-1:0]   addend;
    logic                last_iter;

    assign act_f = fp16_unpack(activation);

    // Negating the most negative weight wraps back to the same bit pattern,
    // which read as unsigned is exactly its magnitude.
    assign w_mag = weight[W_WIDTH-1] ? -weight : weight;

    // w_q is shifted right each iteration so bit 0 is always the current
    // multiplier bit; the counter supplies the matching shift of m.
    always_comb begin
        addend = '0;
        if (w_q[0]) begin
            addend = MANT_W'(m_q) << cnt_q;
        end
        acc_d = acc_q + addend;
    end

    assign last_iter = (cnt_q == CNT_W'(W_WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            m_q        <= '0;
            w_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            sign_out_q <= 1'b0;
            exp_out_q  <= '0;
            mant_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q     <= act_f.sig;
                        w_q     <= w_mag;
                        sign_q  <= act_f.sign ^ weight[W_WIDTH-1];
                        exp_q   <= act_f.exp;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    w_q   <= w_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        mant_out_q <= acc_d;
                        sign_out_q <= sign_q;
                        exp_out_q  <= exp_q;
                        done_q     <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = (state_q == RUN);
    assign sign_out     = sign_out_q;
    assign exp_out      = exp_out_q;
    assign mantissa_out = mant_out_q;
    assign done         = done_q;

endmodule

// File: tb/tb_fp_int_mul.sv
module tb_fp_int_mul;

    logic        clk;
    logic        rst;
    logic [15:0] activation;
    logic [3:0]  weight;
    logic        start;
    logic        busy;
    logic        sign_out;
    logic [4:0]  exp_out;
    logic [14:0] mantissa_out;
    logic        done;

    fp_int_mul #(.ACT_WIDTH(16), .W_WIDTH(4), .ACC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .activation(activation), .weight(weight),
        .start(start), .busy(busy), .sign_out(sign_out), .exp_out(exp_out),
        .mantissa_out(mantissa_out), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       s;
        bit [4:0] e;
        int       m;
        int       cyc;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    bit   have_last;
    int   tests;
    int   fails;
    int   cyc;
    bit   done_prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: the product taken directly from the number definitions.
    function automatic exp_t model(input bit [15:0] a, input bit [3:0] w);
        exp_t r;
        int   e, sig, wv, mag;
        e   = int'(a[14:10]);
        sig = (e != 0 ? 1024 : 0) + int'(a[9:0]);
        wv  = int'(w) - (w[3] ? 16 : 0);
        mag = (wv < 0) ? -wv : wv;
        r.s = a[15] ^ (wv < 0);
        r.e = a[14:10];
        r.m = sig * mag;
        r.cyc = 0;
        return r;
    endfunction

    // Monitor: a rising done presents a result; compare with the queue head.
    always @(negedge clk) begin
        exp_t x;
        if (!rst && done && !done_prev) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                x = q.pop_front();
                check("sign_out", int'(sign_out), int'(x.s));
                check("exp_out", int'(exp_out), int'(x.e));
                check("mantissa_out", int'(mantissa_out), x.m);
                check("done_cycle", cyc, x.cyc);
                check("busy_at_done", int'(busy), 0);
            end
        end
        done_prev = done;
    end

    // Wait at a negedge until the multiplier is idle.
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // Issue one multiply; push its expectation when it is meant to complete.
    task automatic do_op(input bit [15:0] a, input bit [3:0] w, input bit push);
        exp_t x;
        @(negedge clk);
        wait_idle();
        if (have_last) begin
            check("done_held", int'(done), 1);
            check("mant_held", int'(mantissa_out), last_exp.m);
        end
        activation = a;
        weight     = w;
        start      = 1'b1;
        x     = model(a, w);
        x.cyc = cyc + 5;
        if (push) begin
            q.push_back(x);
            last_exp  = x;
            have_last = 1'b1;
        end
        @(negedge clk);
        start      = 1'b0;
        activation = 16'($urandom);
        weight     = 4'($urandom);
        check("busy_after_accept", int'(busy), 1);
        check("done_cleared", int'(done), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_sign"}, int'(sign_out), 0);
        check({tag, "_exp"}, int'(exp_out), 0);
        check({tag, "_mant"}, int'(mantissa_out), 0);
    endtask

    initial begin
        bit [15:0] dir_a [6] = '{16'hC1A9, 16'h3C00, 16'h7BFF, 16'hBC00, 16'h4500, 16'h0001};
        bit [3:0]  dir_w [6] = '{4'd6, 4'b1000, 4'd7, 4'b1111, 4'd0, 4'd3};
        int n;
        tests = 0; fails = 0; cyc = 0; done_prev = 1'b0; have_last = 1'b0;
        start = 1'b0; activation = '0; weight = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Directed cases, back to back.
        for (int i = 0; i < 6; i++) do_op(dir_a[i], dir_w[i], 1'b1);

        // Start pulsed while busy with different operands must be ignored.
        do_op(16'h4248, 4'b1011, 1'b1);
        start = 1'b1; activation = 16'h7C00; weight = 4'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; activation = 16'h0400; weight = 4'd1;
        @(negedge clk);
        start = 1'b0;

        // Reset mid-operation aborts at once.
        do_op(16'h5A5A, 4'd5, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_state("abort");
        have_last = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_op(16'hC1A9, 4'd6, 1'b1);

        // Randomized operands with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            do_op(16'($urandom), 4'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check("results_outstanding", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_int_mul.md
# fp_int_mul

Sequential FP16 × signed-INT4 multiplier for the FP-INT MAC datapath. It unpacks an IEEE-754 half-precision activation and multiplies its significand (hidden bit restored) by the magnitude of a signed integer weight. The multiply is bit-serial shift-add over W_WIDTH cycles. It produces an unnormalized sign/exponent/integer-mantissa triple that the downstream accumulator aligns and sums.

## Interface
Parameters:
- ACT_WIDTH, 16, activation width; FP16 only: 1 sign, 5 exponent, 10 fraction bits.
- W_WIDTH, 4, weight width; two's-complement signed.
- ACC_WIDTH, 32, downstream accumulator width; unused internally and carried for integration consistency.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- activation  in  ACT_WIDTH  FP16 operand; sampled only on an accepted start.
- weight  in  W_WIDTH  signed integer operand; sampled only on an accepted start.
- start  in  1  request; accepted on a rising edge when busy=0.
- busy  out  1  high while a multiply is in progress.
- sign_out  out  1  product sign.
- exp_out  out  5  product exponent: the biased activation exponent, passed through unchanged.
- mantissa_out  out  11+W_WIDTH (15)  unsigned product of significand and |weight|.
- done  out  1  result valid; level signal.

## Operation
- Unpack the activation as s = activation[15], e = activation[14:10], f = activation[9:0].
- Significand m = {(e != 0), f}, 11 bits; subnormals get hidden bit 0.
- Inf/NaN get no special handling; the fields pass through the same path.
- Weight magnitude: |w| = weight[3] ? -weight : weight, held as 4-bit unsigned; -8 gives 8.
- sign_out = s XOR weight[W_WIDTH-1]. A zero weight gives sign_out = s and mantissa_out = 0.
- exp_out = e. The product is not normalized or rounded.
- mantissa_out = m × |w|, exact. The maximum value is 2047×8 = 16376, so it never overflows 15 bits.
- Datapath: 15-bit accumulator, 11-bit m register, W_WIDTH-bit |w| register, and a bit counter of ceil(log2(W_WIDTH+1)) bits.
- Iteration k (k = 0..W_WIDTH-1): if |w|[k] = 1, acc += m << k.
- FSM states:
  - IDLE: busy=0. An accepted start latches the operands, clears acc and the counter, clears done, and moves to RUN.
  - RUN: busy=1, one iteration per cycle. The last iteration moves to IDLE and sets done=1.
- Outputs sign_out, exp_out and mantissa_out are registered. They update only on the completion edge and hold until the next completion or reset.
- done stays high after completion until the next accepted start clears it.

## Timing
- Reset (asynchronous, rst=1): FSM goes to IDLE; busy=0, done=0, sign_out=0, exp_out=0, mantissa_out=0; internal registers are cleared.
- Start accepted at edge T0: busy=1 after T0. Iterations run on edges T0+1 .. T0+W_WIDTH.
- On edge T0+W_WIDTH: results are valid, done=1, busy=0. Latency is W_WIDTH cycles, i.e. 4.
- start while busy=1 is ignored. The operands and the in-flight result are unaffected.
- start on the completion edge is not accepted, because busy is still 1 at that edge. The earliest accepted start is edge T0+W_WIDTH+1.
- activation and weight may change freely after the accept edge.
- Reset asserted mid-operation aborts immediately; all outputs return to their reset values.
- Back-to-back operation is one result per W_WIDTH+1 cycles.

## Structure
- Shared package holds:
  - FP16 field constants: EXP_W=5, FRAC_W=10, SIG_W=11, EXP_BIAS=15.
  - The state enum {IDLE, RUN}.
  - The product-width constant SIG_W+W_WIDTH, so the accumulator can reuse the constants.
- Single module; no sub-module is required.
- An optional combinational fp16_unpack (sign, exp, significand with hidden bit) is the natural split if the accumulator also needs it.

## Test plan
- 0xC1A9 × 6 (4'b0110): after 4 cycles, sign_out=1, exp_out=5'b10000, mantissa_out=15'b010000111110110 (8694), done=1, busy=0.
- 0x3C00 × -8 (4'b1000): sign_out=1, exp_out=5'b01111, mantissa_out=8192.
- 0x7BFF × 7: sign_out=0, exp_out=5'b11110, mantissa_out=14329. Then 0xBC00 × -1: sign_out=0, mantissa_out=1024.
- Zero weight with 0x4500 gives mantissa_out=0, sign_out=0, exp_out=5'b10001. Subnormal 0x0001 × 3 gives exp_out=0, mantissa_out=3.
- Start pulsed again while busy with different operands: it is ignored, and the first result completes unchanged at T0+4.
- rst asserted at T0+2: busy, done and all outputs return to 0 immediately. A new start after reset completes normally in 4 cycles.
